// File: rtl/sample_player_pkg.sv
// Shared definitions for the sample_player block.
//   MODE_LOOP / MODE_ONESHOT : encoding of the mode input
//   state_e                  : playback FSM states
package sample_player_pkg;

  localparam logic MODE_LOOP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PLAY
  } state_e;

endpackage

// File: rtl/sample_ram.sv
// Sample memory: DEPTH x DATA_W, one write port, one synchronous read port.
//   clk, reset_n      : clock, async active-low reset (read register only)
//   wr_en/addr/data   : write port
//   rd_en, rd_addr    : read request; rd_data updates one cycle later
//   rd_data           : read register, holds while rd_en is low
// The array itself is never reset. A read and write of the same address in
// one cycle returns the old contents.
module sample_ram #(
  parameter int    DATA_W    = 16,
  parameter int    DEPTH     = 16,
  parameter int    ADDR_W    = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Gated read keeps the presented sample stable under backpressure, even if
  // its address is rewritten meanwhile.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/sample_player.sv
// Sample-playback source feeding the FIR datapath over valid/ready.
//   clk, reset_n             : clock, async active-low reset
//   wr_en/wr_addr/wr_data    : sample memory write port (usable at any time)
//   start, stop              : begin (IDLE only) / abort playback
//   mode, length             : loop/one-shot and samples per pass, latched at start
//   out_data/out_index       : current sample and its memory index
//   out_valid, out_ready     : output handshake
//   busy                     : playback in progress
//   wrap, done               : pulse with the last-index transfer (loop / one-shot)
module sample_player
  import sample_player_pkg::*;
#(
  parameter int    DATA_W    = 16,
  parameter int    DEPTH     = 16,
  parameter int    ADDR_W    = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [ADDR_W:0]   length,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              wrap,
  output logic              done
);

  state_e            r_state, w_state_next;
  logic              r_mode;
  logic [ADDR_W-1:0] r_last;        // index of the final sample of a pass
  logic [ADDR_W-1:0] r_next_idx;    // index the next RAM read will fetch
  logic              r_fetch_done;  // one-shot: last index already fetched
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_index;

  logic              w_start;
  logic              w_fire;
  logic              w_last_xfer;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_len_last;

  // 0 or anything above DEPTH selects the full memory; DEPTH is a power of
  // two, so its last index is all ones.
  assign w_len_last = (length == '0 || length > (ADDR_W+1)'(DEPTH)) ? '1
                                                                     : length[ADDR_W-1:0] - ADDR_W'(1);

  assign w_start     = (r_state == IDLE) && start && !stop;
  assign w_fire      = r_out_valid && out_ready;
  assign w_last_xfer = w_fire && (r_out_index == r_last);

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) w_state_next = FETCH;
      end
      FETCH: begin
        w_rd_en      = !stop;
        w_state_next = stop ? IDLE : PLAY;
      end
      PLAY: begin
        // Prefetch: refill the output register in the same cycle it empties.
        w_rd_en = !stop && !r_fetch_done && (!r_out_valid || out_ready);
        if (stop || (w_last_xfer && r_mode == MODE_ONESHOT)) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_mode       <= MODE_LOOP;
      r_last       <= '0;
      r_next_idx   <= '0;
      r_fetch_done <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_index  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_mode       <= mode;
        r_last       <= w_len_last;
        r_next_idx   <= '0;
        r_fetch_done <= 1'b0;
      end
      if (w_rd_en) begin
        r_out_index  <= r_next_idx;
        r_next_idx   <= (r_next_idx == r_last) ? '0 : r_next_idx + ADDR_W'(1);
        r_fetch_done <= (r_next_idx == r_last) && (r_mode == MODE_ONESHOT);
      end
      if (w_state_next == IDLE) begin
        r_out_valid <= 1'b0;
      end else if (w_rd_en) begin
        r_out_valid <= 1'b1;
      end else if (w_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  sample_ram #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (w_rd_en),
    .rd_addr (r_next_idx),
    .rd_data (out_data)
  );

  assign out_valid = r_out_valid;
  assign out_index = r_out_index;
  assign busy      = (r_state != IDLE);
  // A transfer in the stop cycle is accepted but does not flag end-of-pass.
  assign wrap      = w_last_xfer && !stop && (r_mode == MODE_LOOP);
  assign done      = w_last_xfer && !stop && (r_mode == MODE_ONESHOT);

endmodule

// File: tb/tb_sample_player.sv
// Randomised scoreboard bench for sample_player (DATA_W 16, DEPTH 16).
module tb_sample_player;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start, stop, mode;
  logic [4:0]  length;
  logic [15:0] out_data;
  logic [3:0]  out_index;
  logic        out_valid, out_ready, busy, wrap, done;

  sample_player #(
    .DATA_W    (16),
    .DEPTH     (16),
    .ADDR_W    (4),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .length    (length),
    .out_data  (out_data),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .wrap      (wrap),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  index;
    logic        wrap;
    logic        done;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_mem [16];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          dw_k [2] = '{-1, -1};
  logic [3:0]  dw_a [2];
  logic [15:0] dw_d [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per handshake, checks hold stability and stray pulses.
  logic        hold_pend = 1'b0;
  logic [15:0] hold_data;
  logic [3:0]  hold_index;
  always @(negedge clk) begin
    if (!reset_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_data);
        chk("hold_index", out_index, hold_index);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer_index", out_index, 32'hffff_ffff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("xfer_cycle", cyc, e.cyc);
          chk("xfer_data", out_data, e.data);
          chk("xfer_index", out_index, e.index);
          chk("xfer_wrap", wrap, e.wrap);
          chk("xfer_done", done, e.done);
        end
      end else begin
        chk("stray_pulse", {wrap, done}, 0);
      end
      hold_pend  = out_valid && !out_ready && !stop;
      hold_data  = out_data;
      hold_index = out_index;
    end
  end

  task automatic rand_write();
    if ($urandom_range(0, 3) == 0) begin
      wr_en   = 1'b1;
      wr_addr = 4'($urandom);
      wr_data = 16'($urandom);
      model_mem[wr_addr] = wr_data;
    end
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_done", done, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    wr_en   = 1'b0;
  endtask

  // One playback. Reference rules: item k shows index k mod len; its data is the
  // memory as read in the cycle the previous item transferred (start+1 for item 0),
  // i.e. before that cycle's write; items transfer on consecutive ready cycles
  // from start+2 on.
  task automatic run(input logic m, input int lenf, input int n_items, input int rdy_mode,
                     input bit stop_en, input int restart_at, input int rst_at,
                     input bit wr_rand);
    int          len, k, kb, stalls, guard, idx;
    bit          rdy, restarted, last, sn;
    logic [15:0] cur;
    len    = (lenf == 0 || lenf > 16) ? 16 : lenf;
    k      = 0;
    stalls = 0;
    guard  = 0;
    restarted = 1'b0;
    mode      = m;
    length    = 5'(lenf);
    start     = 1'b1;
    out_ready = 1'b1;
    step();
    start  = 1'b0;
    mode   = ~m;
    length = 5'($urandom);
    chk("busy_t1", busy, 1);
    chk("valid_t1", out_valid, 0);
    cur   = model_mem[0];
    wr_en = 1'b0;
    if (wr_rand) rand_write();
    step();
    while (k < n_items) begin
      wr_en = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      guard++;
      if (guard > 2000) begin
        chk("run_timeout_items", k, n_items);
        break;
      end
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: begin
          if (k == 2 && stalls < 3) begin
            rdy = 1'b0;
            stalls++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
      out_ready = rdy;
      if (k == rst_at) begin
        do_reset();
        return;
      end
      kb = k;
      if (rdy) begin
        idx  = k % len;
        last = (idx == len - 1);
        sn   = stop_en && (k == n_items - 1);
        stop = sn;
        exp_q.push_back('{data: cur, index: 4'(idx), wrap: !m && last && !sn,
                          done: m && last && !sn, cyc: cyc});
        if (!(m && last) && !sn) cur = model_mem[(k + 1) % len];
        k++;
      end
      for (int i = 0; i < 2; i++) begin
        if (rdy && dw_k[i] == kb) begin
          wr_en   = 1'b1;
          wr_addr = dw_a[i];
          wr_data = dw_d[i];
          model_mem[dw_a[i]] = dw_d[i];
        end
      end
      if (!wr_en && wr_rand) rand_write();
      if (!restarted && restart_at >= 0 && k >= restart_at) begin
        start     = 1'b1;
        mode      = ~m;
        length    = 5'($urandom);
        restarted = 1'b1;
      end
      step();
    end
    wr_en = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    chk("valid_after_end", out_valid, 0);
    chk("busy_after_end", busy, 0);
    out_ready = 1'b1;
    repeat (3) step();
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    start     = 1'b0;
    stop      = 1'b0;
    mode      = 1'b0;
    length    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_data", out_data, 0);
    chk("reset_out_index", out_index, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_wrap", wrap, 0);
    chk("reset_done", done, 0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      wr_data = 16'(i + 1);
      model_mem[i] = 16'(i + 1);
      step();
    end
    wr_en = 1'b0;
    step();

    run(1'b0, 0, 40, 0, 1'b1, -1, -1, 1'b0);   // full loop, wraps twice
    run(1'b1, 5, 5, 0, 1'b0, -1, -1, 1'b0);    // one-shot of five
    run(1'b0, 4, 6, 2, 1'b1, -1, -1, 1'b0);    // 3-cycle stall on index 2
    run(1'b0, 0, 7, 0, 1'b1, 3, -1, 1'b0);     // stop on index 6, restart ignored

    // start together with stop in IDLE: stays idle
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", busy, 0);
    step();
    chk("startstop_busy2", busy, 0);
    chk("startstop_valid", out_valid, 0);

    // 0xBEEF ahead of playback; 0x1234 written as index 13 is being fetched
    dw_k[0] = 3;  dw_a[0] = 4'd10; dw_d[0] = 16'hBEEF;
    dw_k[1] = 12; dw_a[1] = 4'd13; dw_d[1] = 16'h1234;
    run(1'b0, 0, 20, 0, 1'b1, -1, -1, 1'b0);
    dw_k[0] = -1;
    dw_k[1] = -1;

    run(1'b0, 0, 100, 0, 1'b1, -1, 7, 1'b0);   // reset while index 7 presented
    run(1'b1, 16, 16, 1, 1'b0, -1, -1, 1'b0);  // replay after reset
    run(1'b0, 1, 6, 1, 1'b1, -1, -1, 1'b1);    // len 1 loop

    for (int r = 0; r < 12; r++) begin
      logic m;
      int   lf, n;
      m  = 1'($urandom_range(0, 1));
      lf = $urandom_range(0, 31);
      n  = m ? ((lf == 0 || lf > 16) ? 16 : lf) : $urandom_range(1, 40);
      run(m, lf, n, 1, !m, $urandom_range(0, n), -1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
